// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter:
// ALU opcodes, FSM state encodings and opcode legality check.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // True for the opcodes the shared ALU implements
  function automatic logic alu_op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD,
      ALU_SUB, ALU_SLT: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the preferred requester wins
// when valid, otherwise the other one.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // Pick the preferred requester if it is asking, else the other
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with
// round-robin grant and one transaction in flight.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic gnt_vld;
  logic gnt_idx;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  // Offer the grant only while idle and out of reset
  always_comb begin
    req_ready = 2'b00;
    if (!rst && state_q == S_IDLE && gnt_vld)
      req_ready[gnt_idx] = 1'b1;
  end

  // Next-state and register-update logic for the transaction
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          alu_op_d  = gnt_idx ? req_op1 : req_op0;
          alu_in1_d = gnt_idx ? req_a1  : req_a0;
          alu_in2_d = gnt_idx ? req_b1  : req_b0;
          owner_d   = gnt_idx;
          rr_ptr_d  = ~gnt_idx;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_op_legal(alu_op_q)) begin
          rsp_data_d = alu_out;
          rsp_zero_d = alu_zero;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = '0;
          rsp_zero_d = 1'b0;
          rsp_err_d  = 1'b1;
        end
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a small
// behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_op1   (req_op1),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
  );

  // Stand-in for the team ALU; unknown opcodes give junk
  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = {31'h0, $signed(alu_in1) < $signed(alu_in2)};
      default: alu_out = (alu_in1 ^ alu_in2) | 32'h1;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  // Reference result from the opcode meanings
  function automatic void ref_alu(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] d,
                                  output logic z,
                                  output logic e);
    e = 1'b0;
    d = 32'h0;
    case (op)
      4'h0: d = a & b;
      4'h1: d = a | b;
      4'h2: d = a + b;
      4'h6: d = a - b;
      4'h7: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    z = !e && (d == 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_true(input string nm, input bit ok, input int val);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: value %0d out of range", nm, val);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end
  endtask

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  // One isolated transaction with latency and result checks
  task automatic do_txn(input vec_t v, input string nm);
    int n;
    logic [1:0] oh;
    n  = 0;
    oh = v.id ? 2'b10 : 2'b01;
    set_req(v.id, v.op, v.a, v.b);
    req_valid[v.id] = 1'b1;
    #1;
    while (req_ready[v.id] !== 1'b1 && n < 20) begin
      tick; #1; n++;
    end
    if (n >= 20) begin
      total++;
      $display("FAIL %s_grant: no req_ready within %0d cycles", nm, n);
      req_valid = 2'b00;
      return;
    end
    chk({nm, "_rdy"}, {30'h0, req_ready}, {30'h0, oh});
    @(posedge clk);
    #2;
    req_valid[v.id] = 1'b0;
    set_req(v.id, 4'h0, $urandom, $urandom);
    #1;
    chk({nm, "_exec_rv"}, {30'h0, rsp_valid}, 32'h0);
    chk({nm, "_alu_op"}, {28'h0, alu_op}, {28'h0, v.op});
    chk({nm, "_alu_in1"}, alu_in1, v.a);
    tick; #1;
    chk({nm, "_rv"}, {30'h0, rsp_valid}, {30'h0, oh});
    chk({nm, "_data"}, rsp_data, v.data);
    chk({nm, "_zero"}, {31'h0, rsp_zero}, {31'h0, v.zero});
    chk({nm, "_err"}, {31'h0, rsp_err}, {31'h0, v.err});
    rsp_ready[v.id] = 1'b1;
    tick;
    rsp_ready = 2'b00;
    #1;
    chk({nm, "_rv_done"}, {30'h0, rsp_valid}, 32'h0);
  endtask

  bit          pend[2];
  logic [3:0]  pop[2];
  logic [31:0] pa[2], pb[2];
  int          skip[2], served[2];
  logic [3:0]  ops_tbl[7];

  initial begin
    logic        busy, owner, pref, g, acc, done;
    int          age;
    logic [1:0]  exp_rdy, exp_rv;
    logic [3:0]  cur_op;
    logic [31:0] cur_a, cur_b, ed;
    logic        ez, ee;
    int          quiet;

    vecs[0] = '{1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'hF, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, ALU_SLT, 32'd3, 32'd8, 32'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, ALU_SLT, 32'd8, 32'd3, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F,
                32'h0F0F0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, ALU_SUB, 32'd3, 32'd5, 32'hFFFFFFFE,
                1'b0, 1'b0};
    ops_tbl = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hF, 4'h3};

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    set_req(1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1'b1, 4'h0, 32'h0, 32'h0);
    tick; tick; #1;
    chk("rst_rv", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rdy", {30'h0, req_ready}, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_in1", alu_in1, 32'h0);
    chk("rst_op", {28'h0, alu_op}, 32'h0);
    rst = 1'b0;
    tick;

    foreach (vecs[i]) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with the non-owner ready bit set
    set_req(1'b1, ALU_ADD, 32'd100, 32'd23);
    req_valid = 2'b10;
    #1;
    chk("bp_rdy", {30'h0, req_ready}, 32'h2);
    tick;
    req_valid = 2'b01;
    tick;
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b01;
      #1;
      chk($sformatf("bp_rv%0d", i), {30'h0, rsp_valid}, 32'h2);
      chk($sformatf("bp_data%0d", i), rsp_data, 32'd123);
      chk($sformatf("bp_rdy%0d", i), {30'h0, req_ready}, 32'h0);
      tick;
    end
    rsp_ready = 2'b10;
    #1;
    chk("bp_rv_last", {30'h0, rsp_valid}, 32'h2);
    tick;
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    #1;
    chk("bp_done", {30'h0, rsp_valid}, 32'h0);
    tick;

    // Reset while a response is pending
    set_req(1'b1, ALU_ADD, 32'd1, 32'd1);
    req_valid = 2'b10;
    tick;
    req_valid = 2'b00;
    tick; #1;
    chk("mid_rv_pre", {30'h0, rsp_valid}, 32'h2);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_rv", {30'h0, rsp_valid}, 32'h0);
    chk("mid_rst_rdy", {30'h0, req_ready}, 32'h0);
    chk("mid_rst_op", {28'h0, alu_op}, 32'h0);
    req_valid = 2'b00;
    tick;
    rst = 1'b0;
    tick; #1;
    chk("post_rst_rv", {30'h0, rsp_valid}, 32'h0);

    // Contention straight after reset
    tick;
    set_req(1'b0, ALU_SUB, 32'd9, 32'd9);
    set_req(1'b1, ALU_OR, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    #1;
    chk("tie1_rdy", {30'h0, req_ready}, 32'h1);
    tick;
    req_valid[0] = 1'b0;
    #1;
    chk("tie1_exec_rdy", {30'h0, req_ready}, 32'h0);
    tick; #1;
    chk("tie1_rv", {30'h0, rsp_valid}, 32'h1);
    chk("tie1_data", rsp_data, 32'h0);
    chk("tie1_zero", {31'h0, rsp_zero}, 32'h1);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    set_req(1'b0, ALU_AND, 32'hFF00, 32'h0F0F);
    req_valid[0] = 1'b1;
    #1;
    chk("tie2_rdy", {30'h0, req_ready}, 32'h2);
    tick;
    req_valid[1] = 1'b0;
    tick; #1;
    chk("tie2_rv", {30'h0, rsp_valid}, 32'h2);
    chk("tie2_data", rsp_data, 32'hFF);
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
    #1;
    chk("tie3_rdy", {30'h0, req_ready}, 32'h1);
    tick;
    req_valid = 2'b00;
    tick; #1;
    chk("tie3_data", rsp_data, 32'h0F00);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;

    // Random stream against the reference model
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    busy = 1'b0; owner = 1'b0; pref = 1'b0; age = 0;
    cur_op = 4'h0; cur_a = 32'h0; cur_b = 32'h0;
    quiet = 0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; skip[r] = 0; served[r] = 0;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc >= 400 && !busy && !pend[0] && !pend[1]) break;
      for (int r = 0; r < 2; r++) begin
        if (cyc < 400 && !pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          skip[r] = 0;
          pop[r]  = ops_tbl[$urandom_range(0, 6)];
          pa[r]   = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 9);
          pb[r]   = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
          set_req(r[0], pop[r], pa[r], pb[r]);
          req_valid[r] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      g = pend[pref] ? pref : ~pref;
      exp_rdy = 2'b00;
      if (!busy && (pend[0] || pend[1])) exp_rdy = g ? 2'b10 : 2'b01;
      exp_rv = 2'b00;
      if (busy && age >= 2) exp_rv = owner ? 2'b10 : 2'b01;
      chk($sformatf("rnd_rdy_c%0d", cyc), {30'h0, req_ready},
          {30'h0, exp_rdy});
      chk($sformatf("rnd_rv_c%0d", cyc), {30'h0, rsp_valid},
          {30'h0, exp_rv});
      if (exp_rv != 2'b00) begin
        ref_alu(cur_op, cur_a, cur_b, ed, ez, ee);
        chk($sformatf("rnd_data_c%0d", cyc), rsp_data, ed);
        chk($sformatf("rnd_zero_c%0d", cyc), {31'h0, rsp_zero},
            {31'h0, ez});
        chk($sformatf("rnd_err_c%0d", cyc), {31'h0, rsp_err},
            {31'h0, ee});
      end
      acc  = (exp_rdy != 2'b00);
      done = (exp_rv != 2'b00) && rsp_ready[owner];
      if (acc && pend[~g]) begin
        skip[~g]++;
        chk_true($sformatf("starve_c%0d", cyc), skip[~g] <= 1, skip[~g]);
      end
      @(posedge clk);
      #2;
      if (acc) begin
        pend[g] = 1'b0;
        req_valid[g] = 1'b0;
        set_req(g, 4'h0, $urandom, $urandom);
        busy = 1'b1; age = 1; owner = g;
        cur_op = pop[g]; cur_a = pa[g]; cur_b = pb[g];
        pref = ~g;
        served[g]++;
      end else if (busy) begin
        if (done) busy = 1'b0;
        else age++;
      end
      quiet = cyc;
    end
    rsp_ready = 2'b00;
    chk_true("rnd_drained", !busy && !pend[0] && !pend[1], quiet);
    chk_true("rnd_served0", served[0] > 0, served[0]);
    chk_true("rnd_served1", served[1] > 0, served[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
